// File: rtl/comp_serial.sv
// Bit-serial unsigned magnitude comparator with valid/ready on both sides.
// Define COMP_SERIAL_EARLY_EXIT_EN for an MSB-first scan that stops at the first differing bit.
module comp_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [CNT_W-1:0] cnt;
    logic             g;
    logic             l;

    logic xb;
    logic yb;
    logic gn;
    logic ln;
    logic fin;

    always_comb begin
        xb  = 1'b0;
        yb  = 1'b0;
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        xb  = xs[WIDTH-1];
        yb  = ys[WIDTH-1];
`else
        xb  = xs[0];
        yb  = ys[0];
`endif
        gn  = (xb & ~yb) | (~(xb ^ yb) & g);
        ln  = (~xb & yb) | (~(xb ^ yb) & l);
        fin = (cnt == CNT_W'(WIDTH - 1));
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        // A differing MSB-side bit settles the result immediately
        fin = fin | (xb ^ yb);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            xs        <= '0;
            ys        <= '0;
            cnt       <= '0;
            g         <= 1'b0;
            l         <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs       <= x;
                        ys       <= y;
                        g        <= 1'b0;
                        l        <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    g   <= gn;
                    l   <= ln;
                    cnt <= cnt + 1'b1;
`ifdef COMP_SERIAL_EARLY_EXIT_EN
                    xs  <= xs << 1;
                    ys  <= ys << 1;
`else
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
`endif
                    if (fin) begin
                        gt        <= gn;
                        lt        <= ln;
                        eq        <= ~gn & ~ln;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gt        <= 1'b0;
                        eq        <= 1'b0;
                        lt        <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
